// File: rtl/btn_event.sv
// rtl/btn_event.sv - two-button debouncer with press, long-press and held outputs
module btn_event #(
    parameter int CLK_FREQ = 125_000_000,
    parameter int DEB_MS   = 20,
    parameter int LONG_MS  = 3000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN0,
    input  logic       BTN1,
    output logic [1:0] PRESS,
    output logic [1:0] LONG,
    output logic [1:0] HELD
);

    // Clocks per 1 ms tick; clamped so tiny CLK_FREQ values still elaborate.
    localparam int TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [7:0]     DEB_LAST  = 8'(DEB_MS);
    localparam logic [15:0]    LONG_LAST = 16'(LONG_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_PRESSED,
        S_LONG_HELD,
        S_DEB_REL
    } state_t;

    logic [TCW-1:0] tick_cnt;
    logic           tick;
    logic [1:0]     btn_raw;
    logic [1:0]     sync_q1;
    logic [1:0]     sync_q2;

    assign btn_raw = {BTN1, BTN0};
    assign tick    = (tick_cnt == TICK_LAST);

    // Free-running 1 ms prescaler shared by both buttons.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous, bouncing button inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        state_t      state;
        state_t      state_nx;
        logic [7:0]  deb_cnt;
        logic [7:0]  deb_cnt_nx;
        logic [7:0]  deb_inc;
        logic [15:0] hold_cnt;
        logic [15:0] hold_cnt_nx;
        logic [15:0] hold_sat;
        logic        was_long;
        logic        was_long_nx;
        logic        press_q;
        logic        press_nx;
        logic        long_q;
        logic        long_nx;
        logic        held_q;
        logic        held_nx;
        logic        sync_b;

        assign sync_b  = sync_q2[i];
        assign deb_inc = deb_cnt + 8'd1;
        // Hold count stops at all-ones rather than wrapping back to zero.
        assign hold_sat = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;

        assign PRESS[i] = press_q;
        assign LONG[i]  = long_q;
        assign HELD[i]  = held_q;

        // State, counters and registered event outputs for this button.
        always_ff @(posedge CLK) begin
            if (RST) begin
                state    <= S_IDLE;
                deb_cnt  <= 8'd0;
                hold_cnt <= 16'd0;
                was_long <= 1'b0;
                press_q  <= 1'b0;
                long_q   <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                state    <= state_nx;
                deb_cnt  <= deb_cnt_nx;
                hold_cnt <= hold_cnt_nx;
                was_long <= was_long_nx;
                press_q  <= press_nx;
                long_q   <= long_nx;
                held_q   <= held_nx;
            end
        end

        // Next-state logic; pulses are flagged on the transition edge so the
        // registered copy lands in the first cycle of the destination state.
        always_comb begin
            state_nx    = state;
            deb_cnt_nx  = deb_cnt;
            hold_cnt_nx = hold_cnt;
            was_long_nx = was_long;
            press_nx    = 1'b0;
            long_nx     = 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync_b) begin
                        state_nx   = S_DEB_PRESS;
                        deb_cnt_nx = 8'd0;
                    end
                end
                S_DEB_PRESS: begin
                    if (!sync_b) begin
                        state_nx = S_IDLE;
                    end else if (tick) begin
                        deb_cnt_nx = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            state_nx    = S_PRESSED;
                            hold_cnt_nx = 16'd0;
                            was_long_nx = 1'b0;
                            press_nx    = 1'b1;
                        end
                    end
                end
                S_PRESSED: begin
                    // A release takes priority over a coincident tick.
                    if (!sync_b) begin
                        state_nx    = S_DEB_REL;
                        deb_cnt_nx  = 8'd0;
                        was_long_nx = 1'b0;
                    end else if (tick) begin
                        hold_cnt_nx = hold_sat;
                        if (hold_sat == LONG_LAST) begin
                            state_nx = S_LONG_HELD;
                            long_nx  = 1'b1;
                        end
                    end
                end
                S_LONG_HELD: begin
                    if (!sync_b) begin
                        state_nx    = S_DEB_REL;
                        deb_cnt_nx  = 8'd0;
                        was_long_nx = 1'b1;
                    end
                end
                S_DEB_REL: begin
                    // Bounce back up resumes where we left off, hold count intact.
                    if (sync_b) begin
                        state_nx = was_long ? S_LONG_HELD : S_PRESSED;
                    end else if (tick) begin
                        deb_cnt_nx = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            state_nx = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
            held_nx = (state_nx == S_PRESSED) || (state_nx == S_LONG_HELD) ||
                      (state_nx == S_DEB_REL);
        end
    end

endmodule
